// File: rtl/bcd_seg7_pkg.sv
// Shared constants and the BCD to 7-segment mapping
// used by the multiplexed display scanner.
package bcd_seg7_pkg;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  // Non-decimal nibbles show a dash so bad data is visible.
  function automatic logic [6:0] seg7_decode(
    input logic [3:0] nib
  );
    if (nib > 4'd9) return SEG_DASH;
    return SEG_DIGIT[nib];
  endfunction

endpackage

// File: rtl/bcd_seg7_scanner_bcd_to_seg7.sv
// Combinational nibble to active-high segment decode,
// {g,f,e,d,c,b,a}; invalid codes map to a dash.
module bcd_to_seg7
  import bcd_seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = seg7_decode(nib);

endmodule

// File: rtl/bcd_seg7_scanner.sv
// Time-multiplexed 7-segment driver: snapshots all BCD
// digits once per frame, then scans one digit per slot.
module bcd_seg7_scanner
  import bcd_seg7_pkg::*;
#(
  parameter int DIGITS         = 3,
  parameter int PRESCALE       = 1000,
  parameter int BLANK_CYCLES   = 2,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic                  lzb_en,
  input  logic [DIGITS-1:0]     dp_mask,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     dig_en,
  output logic                  frame_start
);

  localparam int PW = $clog2(PRESCALE);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PW-1:0] P_LAST  = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYCLES);
  localparam logic [IW-1:0] I_LAST  = IW'(DIGITS - 1);

  localparam logic [6:0] SEG_XOR =
    (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic DP_XOR = (SEG_ACTIVE_LOW != 0);
  localparam logic [DIGITS-1:0] DIG_XOR =
    (DIG_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : '0;

  logic [PW-1:0]       p;
  logic [IW-1:0]       i;
  logic [4*DIGITS-1:0] snap;

  logic                last_p;
  logic                last_i;
  logic                load;
  logic                in_blank;

  logic [3:0]          nib;
  logic [6:0]          dec_seg;
  logic [DIGITS-1:0]   lzb_mask;

  logic [6:0]          seg_n;
  logic                dp_n;
  logic [DIGITS-1:0]   dig_n;

  assign last_p   = (p == P_LAST);
  assign last_i   = (i == I_LAST);
  assign load     = (p == '0) && (i == '0);
  assign in_blank = (p < P_BLANK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p <= '0;
      i <= '0;
    end else if (ena) begin
      if (last_p) begin
        p <= '0;
        i <= last_i ? '0 : i + 1'b1;
      end else begin
        p <= p + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap        <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= ena && load;
      if (ena && load) snap <= bcd_in;
    end
  end

  assign nib = snap[4*i +: 4];

  bcd_to_seg7 u_dec (
    .nib (nib),
    .seg (dec_seg)
  );

  // A digit blanks while it and every more significant
  // digit are zero; the units digit always shows.
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    lzb_mask   = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_above  = zero_above && (snap[4*k +: 4] == 4'd0);
      lzb_mask[k] = lzb_en && zero_above && (k > 0);
    end
  end

  always_comb begin
    seg_n = lzb_mask[i] ? SEG_OFF : dec_seg;
    dp_n  = dp_mask[i] && !in_blank;
    dig_n = in_blank ? '0 : (DIGITS'(1) << i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg    <= SEG_XOR;
      dp     <= DP_XOR;
      dig_en <= DIG_XOR;
    end else if (ena) begin
      seg    <= seg_n ^ SEG_XOR;
      dp     <= dp_n ^ DP_XOR;
      dig_en <= dig_n ^ DIG_XOR;
    end
  end

endmodule
